// File: rtl/onehot_seq_encoder.sv
// Emits the binary index of every set bit of an accepted request vector, one per valid/ready transfer.
// Scan order: lowest bit first by default; define ENC_MSB_FIRST_EN for highest bit first.
module onehot_seq_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pend;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             w_xfer;

  // Selection looks only at registered pend, so nothing from out_ready reaches out_idx/out_last.
  always_comb begin
    w_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (r_pend[i]) w_idx = i[IDX_W-1:0];
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pend[i]) w_idx = i[IDX_W-1:0];
    end
`endif
  end

  assign w_last    = (r_pend != '0) && ((r_pend & (r_pend - ONE)) == '0);
  assign w_xfer    = (r_state == SCAN) && out_ready;

  assign in_ready  = (r_state == IDLE) && resetn;
  assign out_valid = (r_state == SCAN);
  assign busy      = (r_state == SCAN);
  assign out_idx   = w_idx;
  assign out_last  = w_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // An all-zero vector is consumed here without producing any transfer.
          if (in_valid && in_vec != '0) begin
            r_pend  <= in_vec;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_xfer) begin
            r_pend <= r_pend & ~(ONE << w_idx);
            if (w_last) r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pend  <= '0;
        end
      endcase
    end
  end

endmodule
